pulse_meter: RTL and testbench
==============================

PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of all cycle counters and measurement outputs.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 sig  input  1  asynchronous pulse train under measurement.
REQ-005 high_len  output  WIDTH  clk cycles sig was high in the last completed period.
REQ-006 period_len  output  WIDTH  clk cycles between the last two rising edges of sig.
REQ-007 meas_valid  output  1  one-cycle strobe: high_len/period_len/meas_ovf just updated.
REQ-008 meas_ovf  output  1  the last measurement saturated.
REQ-009 locked  output  1  high when the FSM is not in WAIT.

Function
REQ-010 sig SHALL pass through a two-flop synchronizer (sig_s), then one further flop (sig_d).
REQ-011 rise = sig_s & ~sig_d; fall = ~sig_s & sig_d. rise and fall are mutually exclusive.
REQ-012 FSM states SHALL be WAIT, HIGH and LOW; the reset state SHALL be WAIT.
REQ-013 WAIT: cnt held; on rise: cnt <= 1, sat <= 0, go to HIGH.
REQ-014 HIGH: cnt <= cnt+1 each cycle; on fall: hi_cap <= cnt, hi_sat <= sat, go to LOW.
REQ-015 LOW: cnt <= cnt+1 each cycle; on rise: high_len <= hi_cap, period_len <= cnt, meas_ovf <= sat, meas_valid <= 1, cnt <= 1, sat <= 0, go to HIGH.
REQ-016 The counter SHALL saturate at 2^WIDTH-1 and never wrap. Reaching saturation SHALL set sat, which stays set until the next rise.
REQ-017 hi_cap saturates with cnt; meas_ovf reports saturation of either the high phase or the period.
REQ-018 meas_valid SHALL be high for exactly one cycle per completed period. It is never asserted for the first rise after reset.
REQ-019 high_len, period_len and meas_ovf SHALL hold their values between strobes.
REQ-020 Latency: meas_valid SHALL assert on the clock edge where rise is detected. That edge is 3 clk edges after sig rises, when sig meets setup.
REQ-021 For consecutive periods, the block SHALL measure back-to-back without re-entering WAIT.
REQ-022 Minimum measurable input: high >= 1 and low >= 1 synchronized cycle, giving high_len=1 and period_len=2.
REQ-023 A sig held constant SHALL leave the FSM in its current state, with cnt saturating and no strobe.
REQ-024 locked = (state != WAIT).

Reset
REQ-025 rst_n low SHALL asynchronously clear all of the following: synchronizer flops, sig_d, cnt, hi_cap, sat, hi_sat, high_len, period_len, meas_valid, meas_ovf. state <= WAIT; locked = 0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial measurement. After release, the first rise re-arms without a strobe.
REQ-027 Deassertion SHALL be sampled on clk. Measurement resumes only after a fresh rise is seen post-release.

Verification
REQ-028 sig: 4 cycles high / 6 cycles low, repeated. Required: from the second rise onward, meas_valid pulses every 10 cycles with high_len=4, period_len=10, meas_ovf=0.
REQ-029 sig: 1 high / 1 low. Required: high_len=1, period_len=2, with a strobe every 2 cycles.
REQ-030 WIDTH=8; sig: 300 cycles high, then 10 low, then a rise. Required: high_len=255, period_len=255, meas_ovf=1. The next normal period clears meas_ovf.
REQ-031 After reset only one rise occurs. Required: locked=1, meas_valid never asserts, outputs stay 0.
REQ-032 rst_n pulsed low during the LOW phase. Required: all outputs 0 immediately and locked=0. The first post-reset rise gives no strobe; the second gives a correct measurement.
REQ-033 sig driven by a 2-cycle-period clock-derived pulse (1 high/1 low) against a 5-cycle-high, 10-cycle-period pulse. Required: measurements 1/2 and 5/10 respectively.

Source files
------------

// File: rtl/pulse_meter.sv
// Measures high time and period of an asynchronous pulse train in clk cycles.
// Counters saturate at all-ones; a one-cycle strobe marks each completed period.
module pulse_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    output logic [WIDTH-1:0] high_len,
    output logic [WIDTH-1:0] period_len,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic             locked
);
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {WAIT, HIGH, LOW} state_t;
    state_t state;

    logic             sig_m, sig_s, sig_d;
    logic             rise, fall;
    logic [WIDTH-1:0] cnt, hi_cap, cnt_inc;
    logic             sat, hi_sat, inc_sat;

    assign rise    = sig_s & ~sig_d;
    assign fall    = ~sig_s & sig_d;
    assign cnt_inc = (cnt == MAX) ? MAX : cnt + 1'b1;
    // sat is raised on the edge where the counter lands on all-ones
    assign inc_sat = (cnt_inc == MAX);
    assign locked  = (state != WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_m <= 1'b0;
            sig_s <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig_m <= sig;
            sig_s <= sig_m;
            sig_d <= sig_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT;
            cnt        <= '0;
            hi_cap     <= '0;
            sat        <= 1'b0;
            hi_sat     <= 1'b0;
            high_len   <= '0;
            period_len <= '0;
            meas_valid <= 1'b0;
            meas_ovf   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                WAIT: begin
                    if (rise) begin
                        cnt   <= WIDTH'(1);
                        sat   <= 1'b0;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    cnt <= cnt_inc;
                    if (inc_sat) sat <= 1'b1;
                    if (fall) begin
                        hi_cap <= cnt;
                        hi_sat <= sat;
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_len   <= hi_cap;
                        period_len <= cnt;
                        meas_ovf   <= sat | hi_sat;
                        meas_valid <= 1'b1;
                        cnt        <= WIDTH'(1);
                        sat        <= 1'b0;
                        state      <= HIGH;
                    end else begin
                        cnt <= cnt_inc;
                        if (inc_sat) sat <= 1'b1;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: drives sig on negedges, logs every strobe,
// and checks logged measurements against hand-computed values.
module tb_pulse_meter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig = 1'b0;
    logic [7:0] high_len, period_len;
    logic       meas_valid, meas_ovf, locked;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hi_q[$], per_q[$], ovf_q[$], cyc_q[$];

    pulse_meter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sig(sig),
        .high_len(high_len), .period_len(period_len),
        .meas_valid(meas_valid), .meas_ovf(meas_ovf), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (meas_valid) begin
            hi_q.push_back(int'(high_len));
            per_q.push_back(int'(period_len));
            ovf_q.push_back(int'(meas_ovf));
            cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        hi_q.delete(); per_q.delete(); ovf_q.delete(); cyc_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        sig   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic drive(input int hi, input int lo);
        sig = 1'b1;
        repeat (hi) @(negedge clk);
        sig = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic chk_meas(input string tag, input int idx, input int hi, input int per, input int ovf);
        if (idx >= hi_q.size()) begin
            total++; bad++;
            $error("FAIL %s: observed=%0d strobes expected>%0d", tag, hi_q.size(), idx);
        end else begin
            chk({tag, "_hi"}, hi_q[idx], hi);
            chk({tag, "_per"}, per_q[idx], per);
            chk({tag, "_ovf"}, ovf_q[idx], ovf);
        end
    endtask

    initial begin
        int rise_cyc;

        // reset state
        #1;
        chk("rst_high_len", int'(high_len), 0);
        chk("rst_period_len", int'(period_len), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_ovf", int'(meas_ovf), 0);
        chk("rst_locked", int'(locked), 0);
        do_reset();

        // 4 high / 6 low, five rises -> four strobes spaced 10 cycles apart
        repeat (4) drive(4, 6);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        chk("p46_count", hi_q.size(), 4);
        chk_meas("p46_first", 0, 4, 10, 0);
        chk_meas("p46_last", 3, 4, 10, 0);
        if (cyc_q.size() >= 2) chk("p46_gap", cyc_q[1] - cyc_q[0], 10);
        chk("p46_locked", int'(locked), 1);

        // minimum pulse: 1 high / 1 low
        do_reset();
        repeat (5) drive(1, 1);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        chk("p11_count", hi_q.size(), 5);
        chk_meas("p11", 4, 1, 2, 0);
        if (cyc_q.size() >= 5) chk("p11_gap", cyc_q[4] - cyc_q[3], 2);

        // saturation, then a normal period clears the overflow flag
        do_reset();
        drive(300, 10);
        drive(4, 6);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        chk("sat_count", hi_q.size(), 2);
        chk_meas("sat", 0, 255, 255, 1);
        chk_meas("sat_next", 1, 4, 10, 0);
        chk("sat_hold_ovf", int'(meas_ovf), 0);

        // a single rise locks but never strobes
        do_reset();
        sig = 1'b1;
        repeat (20) @(negedge clk);
        chk("one_locked", int'(locked), 1);
        chk("one_count", hi_q.size(), 0);
        chk("one_high_len", int'(high_len), 0);
        chk("one_period_len", int'(period_len), 0);

        // reset in LOW phase discards everything; re-arm without strobe
        do_reset();
        drive(4, 6);
        drive(4, 3);
        chk("mid_pre_high", int'(high_len), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_high", int'(high_len), 0);
        chk("mid_rst_per", int'(period_len), 0);
        chk("mid_rst_locked", int'(locked), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        chk("mid_rel_locked", int'(locked), 0);
        drive(4, 6);
        chk("mid_first_count", hi_q.size(), 0);
        sig = 1'b1;
        rise_cyc = cyc;
        repeat (5) @(negedge clk);
        chk("mid_second_count", hi_q.size(), 1);
        chk_meas("mid_second", 0, 4, 10, 0);
        if (cyc_q.size() >= 1) chk("mid_latency", cyc_q[0] - rise_cyc, 3);

        // switch from 1/2 pulses to 5/10 pulses without leaving lock
        do_reset();
        repeat (3) drive(1, 1);
        repeat (2) drive(5, 5);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        chk("mix_count", hi_q.size(), 5);
        chk_meas("mix_fast", 2, 1, 2, 0);
        chk_meas("mix_slow", 4, 5, 10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
